// File: rtl/mystery_stream_driver_if.sv
// Bus between the upstream source and the stream driver: load/ready handshake,
// captured operands, pause, and the serial x1/x2/s stream with its framing.
interface mystery_stream_driver_if #(
  parameter int W = 8
);
  logic         load;
  logic         ready;
  logic [W-1:0] word_a;
  logic [W-1:0] word_b;
  logic [W-1:0] sel_word;
  logic [1:0]   mode;
  logic         pause;
  logic         x1;
  logic         x2;
  logic         s;
  logic         valid;
  logic         last;
  logic         done;

  // Upstream side: issues transfers and consumes the stream.
  modport master (
    output load, word_a, word_b, sel_word, mode, pause,
    input  ready, x1, x2, s, valid, last, done
  );

  // Driver side.
  modport slave (
    input  load, word_a, word_b, sel_word, mode, pause,
    output ready, x1, x2, s, valid, last, done
  );
endinterface

// File: rtl/mystery_stream_driver.sv
// Serializes two captured words MSB-first onto x1/x2 and generates the select s
// for a downstream 2:1 selector, with valid/last/done framing.
module mystery_stream_driver #(
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mystery_stream_driver_if.slave bus
);

  localparam int CW = $clog2(W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] MODE_ZERO = 2'b00;
  localparam logic [1:0] MODE_ONE  = 2'b01;
  localparam logic [1:0] MODE_ALT  = 2'b10;

  // Parity of the MSB index: alternate mode emits 0 on the MSB.
  localparam logic MSB_PAR = 1'((W - 1) % 2);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sel_q;
  logic [1:0]    mode_q;

  // NOTE: the captured data registers are reset too, so x1/x2/s are
  // guaranteed 0 out of reset regardless of what decodes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sel_q  <= '0;
      mode_q <= MODE_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            a_q    <= bus.word_a;
            b_q    <= bus.word_b;
            sel_q  <= bus.sel_word;
            mode_q <= bus.mode;
            cnt    <= CW'(W - 1);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          // pause freezes the counter, so every decoded output holds too.
          if (!bus.pause) begin
            if (cnt == '0) state <= DONE;
            else           cnt   <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic in_shift;
  logic s_bit;

  // NOTE: every output below gets a default first, so no latch is inferred.
  always_comb begin
    in_shift = (state == SHIFT);
    case (mode_q)
      MODE_ZERO: s_bit = 1'b0;
      MODE_ONE:  s_bit = 1'b1;
      MODE_ALT:  s_bit = MSB_PAR ^ cnt[0];
      default:   s_bit = sel_q[cnt];
    endcase

    bus.ready = (state == IDLE);
    bus.valid = in_shift;
    bus.done  = (state == DONE);
    bus.last  = in_shift && (cnt == '0);
    bus.x1    = 1'b0;
    bus.x2    = 1'b0;
    bus.s     = 1'b0;
    if (in_shift) begin
      bus.x1 = a_q[cnt];
      bus.x2 = b_q[cnt];
      bus.s  = s_bit;
    end
  end

endmodule

// File: tb/tb_mystery_stream_driver.sv
// Directed bench for mystery_stream_driver (W=8): per-mode streams, pause,
// ignored loads, and mid-transfer reset, against hand-computed vectors.
module tb_mystery_stream_driver;

  logic clk;
  logic rst_n;

  mystery_stream_driver_if #(.W(8)) bus ();

  mystery_stream_driver #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive a load on the next edge; return at the negedge of the first bit cycle.
  task automatic start(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] sel, input logic [1:0] md);
    @(negedge clk);
    bus.word_a   = a;
    bus.word_b   = b;
    bus.sel_word = sel;
    bus.mode     = md;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic chk_bit(input string tag, input int k, input logic [7:0] a,
                         input logic [7:0] b, input logic exp_s, input logic exp_f);
    logic f_obs;
    f_obs = bus.s ? bus.x2 : bus.x1;
    check({tag, "_valid"}, 32'(bus.valid), 32'd1);
    check({tag, "_ready"}, 32'(bus.ready), 32'd0);
    check({tag, "_done"},  32'(bus.done),  32'd0);
    check({tag, "_x1"},    32'(bus.x1),    32'(a[k]));
    check({tag, "_x2"},    32'(bus.x2),    32'(b[k]));
    check({tag, "_s"},     32'(bus.s),     32'(exp_s));
    check({tag, "_f"},     32'(f_obs),     32'(exp_f));
    check({tag, "_last"},  32'(bus.last),  32'(k == 0));
  endtask

  task automatic chk_done_then_ready(input string tag);
    check({tag, "_done_pulse"}, 32'(bus.done),  32'd1);
    check({tag, "_done_valid"}, 32'(bus.valid), 32'd0);
    check({tag, "_done_last"},  32'(bus.last),  32'd0);
    check({tag, "_done_ready"}, 32'(bus.ready), 32'd0);
    check({tag, "_done_xs"},    32'({bus.x1, bus.x2, bus.s}), 32'd0);
    @(negedge clk);
    check({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
    check({tag, "_done_clear"}, 32'(bus.done),  32'd0);
    check({tag, "_idle_valid"}, 32'(bus.valid), 32'd0);
  endtask

  // Full transfer; with disturb set, loads and a new word_a arrive mid-shift.
  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] sel, input logic [1:0] md,
                     input logic [7:0] exp_s, input logic [7:0] exp_f, input bit disturb);
    start(a, b, sel, md);
    for (int i = 0; i < 8; i++) begin
      chk_bit($sformatf("%s_b%0d", tag, 7 - i), 7 - i, a, b, exp_s[7-i], exp_f[7-i]);
      if (disturb && i == 2) begin
        bus.load   = 1'b1;
        bus.word_a = 8'h00;
        bus.mode   = 2'b00;
      end
      if (disturb && i == 5) bus.load = 1'b0;
      @(negedge clk);
    end
    chk_done_then_ready(tag);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.word_a   = '0;
    bus.word_b   = '0;
    bus.sel_word = '0;
    bus.mode     = 2'b00;
    bus.pause    = 1'b0;
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_last",  32'(bus.last),  32'd0);
    check("rst_xs",    32'({bus.x1, bus.x2, bus.s}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode 00: f follows x1 = A5.
    run("m00", 8'hA5, 8'h3C, 8'h00, 2'b00, 8'h00, 8'hA5, 1'b0);
    // Mode 01: f follows x2 = 3C; stray loads and word_a change mid-transfer.
    run("m01", 8'hA5, 8'h3C, 8'h00, 2'b01, 8'hFF, 8'h3C, 1'b1);
    // Mode 10: s alternates starting at 0 on the MSB.
    run("m10", 8'hA5, 8'h3C, 8'h00, 2'b10, 8'h55, 8'hB4, 1'b0);
    // Mode 11: s from sel_word F0.
    run("m11", 8'hA5, 8'h3C, 8'hF0, 2'b11, 8'hF0, 8'h35, 1'b0);

    // Pause 3 cycles at bit 4 and 2 cycles on the final bit.
    start(8'hA5, 8'h3C, 8'h00, 2'b00);
    for (int k = 7; k >= 0; k--) begin
      chk_bit($sformatf("pz_b%0d", k), k, 8'hA5, 8'h3C, 1'b0, 8'hA5 >> k & 8'h01);
      if (k == 4 || k == 0) begin
        bus.pause = 1'b1;
        repeat (k == 4 ? 3 : 2) begin
          @(negedge clk);
          chk_bit($sformatf("pz_hold_b%0d", k), k, 8'hA5, 8'h3C, 1'b0, 8'hA5 >> k & 8'h01);
        end
        bus.pause = 1'b0;
      end
      @(negedge clk);
    end
    chk_done_then_ready("pz");

    // Reset mid-shift aborts immediately with no done pulse.
    start(8'hFF, 8'hFF, 8'hFF, 2'b01);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.valid), 32'd0);
    check("arst_ready", 32'(bus.ready), 32'd1);
    check("arst_done",  32'(bus.done),  32'd0);
    check("arst_xs",    32'({bus.x1, bus.x2, bus.s}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_no_done",  32'(bus.done),  32'd0);
    check("arst_idle_rdy", 32'(bus.ready), 32'd1);

    // Normal operation after reset release.
    run("post_rst", 8'h3C, 8'hA5, 8'h00, 2'b00, 8'h00, 8'h3C, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mystery_stream_driver.md
Name: mystery_stream_driver

Overview:
- Upstream driver stage for the team's 2:1 selector (f = s ? x2 : x1). It feeds that block's x1, x2 and s inputs.
- Accepts two W-bit data words plus a select control through a load/ready handshake.
- Serializes both words MSB-first, one bit per clock, onto x1 and x2, and generates s according to a captured select mode, so the downstream selector produces a defined bit stream on f.
- Provides valid, last and done framing so a downstream capture stage can frame the stream.

Parameters:
- W, 8, word width and number of serial bits per transfer; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load  input  1  request to start a transfer; sampled only while ready=1
- ready  output  1  high when the block is idle and can accept load
- word_a  input  W  data serialized onto x1; captured on accepted load
- word_b  input  W  data serialized onto x2; captured on accepted load
- sel_word  input  W  per-bit select pattern, used in mode 2'b11; captured on accepted load
- mode  input  2  select mode, captured on accepted load: 00 s=0, 01 s=1, 10 alternate, 11 pattern
- pause  input  1  stall during SHIFT; holds all outputs and the bit counter
- x1  output  1  current serial bit of captured word_a
- x2  output  1  current serial bit of captured word_b
- s  output  1  select for the downstream selector
- valid  output  1  x1/x2/s carry a live bit
- last  output  1  high with the final bit (index 0)
- done  output  1  one-cycle pulse after the final bit

Behaviour:
- One clock domain (clk), rising edge. Reset rst_n is asynchronous and active-low.
- While rst_n=0:
  - State is IDLE and the bit counter is 0.
  - Captured registers are all 0.
  - Outputs: x1=x2=s=valid=last=done=0, ready=1.
- Reset asserted mid-transfer aborts the transfer immediately; no done pulse is generated.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1, valid=0.
  - load=1 at an edge captures word_a, word_b, sel_word and mode, sets the counter to W-1, and moves to SHIFT.
- SHIFT:
  - valid=1 and ready=0.
  - Outputs carry bit index k = counter: x1=a[k], x2=b[k].
  - s by mode: 00 gives 0; 01 gives 1; 10 gives (W-1-k) mod 2, i.e. 0 on the MSB and alternating after; 11 gives sel[k].
  - last=1 when k=0.
  - If pause=0, each edge decrements k.
  - When k=0 and pause=0, the next state is DONE.
  - If pause=1, the state, the counter and all outputs hold unchanged. This includes pause on the final bit.
- DONE:
  - done=1, valid=0, last=0, x1=x2=s=0, ready=0.
  - Moves unconditionally to IDLE on the next edge.
- Latency:
  - Bit W-1 appears the cycle after the load edge.
  - Bit 0 appears W cycles after the load edge, with no pauses.
  - done follows in the next cycle; ready returns the cycle after done.
  - One transfer occupies W+1 cycles from the load edge to ready.
- load while ready=0 is ignored and is not queued. Changes to the inputs after capture have no effect on the transfer in progress.
- pause in IDLE or DONE has no effect.
- load held high continuously starts a new transfer on each IDLE cycle, i.e. back-to-back transfers with a one-cycle ready gap.
- Outside SHIFT, x1, x2 and s are forced to 0.

Test Plan:
- Reset check: assert rst_n=0 mid-SHIFT. Immediately: valid=0, x1=x2=s=0, ready=1, no done pulse. After release, a new load works normally.
- Mode 00 (W=8, a=8'hA5, b=8'h3C): f and x1 sequence is 1,0,1,0,0,1,0,1, with s=0 throughout. last is on the 8th valid bit, done on the next cycle, ready 9 cycles after the load edge.
- Mode 01 (same words): s=1 throughout and f = 0,0,1,1,1,1,0,0.
- Mode 10 (same words): s = 0,1,0,1,0,1,0,1 and f = 1,0,1,1,0,1,0,0.
- Mode 11 (sel_word=8'hF0): s = 1,1,1,1,0,0,0,0 and f = 0,0,1,1,0,1,0,1.
- Pause and ignored load:
  - pause=1 for 3 cycles at bit index 4 holds all outputs, then the sequence resumes. Total transfer time is 12 cycles.
  - pause=1 on the final bit holds last=1 until released.
  - load pulses issued during SHIFT are ignored.
  - Captured words remain intact when word_a is changed mid-transfer.
